alu_cmd_pipe: RTL and testbench

Command buffer and result register wrapped around the 4-bit combinational ALU (sel: 00 add, 01 sub, 10 and, 11 or). It accepts operand/opcode commands over a valid/ready handshake and queues them in a DEPTH-entry FIFO. The FIFO head drives the ALU inputs directly. The block registers the ALU's result, carry and zero flags into an output stage that has its own valid/ready handshake. It sits directly upstream of the ALU and also captures the ALU's output, making the ALU a pipelined, back-pressurable unit.

---
 rtl/alu_cmd_pipe_if.sv | 49 ++++
 rtl/alu_cmd_pipe.sv | 99 +++++++++
 tb/tb_alu_cmd_pipe.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_pipe_if.sv
// Bundle of the command, ALU-side and result signals of alu_cmd_pipe.
// The master modport is the environment (producer, ALU, consumer); slave is the pipe.
interface alu_cmd_pipe_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic [1:0]    in_sel;

    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [1:0]    alu_sel;
    logic [3:0]    alu_result;
    logic          alu_carry;
    logic          alu_zero;

    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_result;
    logic          out_carry;
    logic          out_zero;
    logic [1:0]    out_sel;

    logic [LW-1:0] level;

    modport master (
        output in_valid, in_a, in_b, in_sel,
        input  in_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result, alu_carry, alu_zero,
        input  out_valid, out_result, out_carry, out_zero, out_sel,
        output out_ready,
        input  level
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel,
        output in_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result, alu_carry, alu_zero,
        output out_valid, out_result, out_carry, out_zero, out_sel,
        input  out_ready,
        output level
    );
endinterface

// File: rtl/alu_cmd_pipe.sv
// Command FIFO in front of an external combinational 4-bit ALU, with a
// registered, back-pressurable result stage capturing the ALU outputs.
module alu_cmd_pipe #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_cmd_pipe_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          empty;
    logic          push;
    logic          load;

    logic          out_valid_q;
    logic [3:0]    out_result_q;
    logic          out_carry_q;
    logic          out_zero_q;
    logic [1:0]    out_sel_q;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; a source holds its data until then, and ready never depends
    // on the same-side valid (in_ready looks at level only, no full bypass).
    assign empty        = (level_q == '0);
    assign bus.in_ready = (level_q < LW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign load         = !empty && (!out_valid_q || bus.out_ready);

    assign head        = mem[rd_ptr];
    assign bus.alu_a   = empty ? 4'd0 : head.a;
    assign bus.alu_b   = empty ? 4'd0 : head.b;
    assign bus.alu_sel = empty ? 2'd0 : head.sel;

    // Storage needs no reset: entries are only visible while level covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, sel: bus.in_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, load})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Result stage: data only changes on a load, so it is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 4'd0;
            out_carry_q  <= 1'b0;
            out_zero_q   <= 1'b0;
            out_sel_q    <= 2'd0;
        end else if (load) begin
            out_valid_q  <= 1'b1;
            out_result_q <= bus.alu_result;
            out_carry_q  <= bus.alu_carry;
            out_zero_q   <= bus.alu_zero;
            out_sel_q    <= head.sel;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_carry  = out_carry_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_sel    = out_sel_q;
    assign bus.level      = level_q;
endmodule

// File: tb/tb_alu_cmd_pipe.sv
// Directed bench for alu_cmd_pipe: behavioural ALU on the alu_* side,
// hand-computed expected words {sel, carry, zero, result} in a scoreboard queue.
module tb_alu_cmd_pipe;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int xfers    = 0;

    logic [7:0] exp_q[$];
    int         xfer_cyc[$];

    alu_cmd_pipe_if #(.DEPTH(DEPTH)) bus ();

    alu_cmd_pipe #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ALU (sel: 00 add, 01 sub, 10 and, 11 or) ----------------
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = 5'd0;
        case (bus.alu_sel)
            2'b00:   alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            2'b01:   alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
            2'b10:   alu_sum = {1'b0, bus.alu_a & bus.alu_b};
            default: alu_sum = {1'b0, bus.alu_a | bus.alu_b};
        endcase
        bus.alu_result = alu_sum[3:0];
        bus.alu_carry  = alu_sum[4];
        bus.alu_zero   = (alu_sum[3:0] == 4'd0);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] out_word();
        return {bus.out_sel, bus.out_carry, bus.out_zero, bus.out_result};
    endfunction

    task automatic check_reset(input string p);
        check({p, "_in_ready"},   32'(bus.in_ready),   32'd1);
        check({p, "_level"},      32'(bus.level),      32'd0);
        check({p, "_out_valid"},  32'(bus.out_valid),  32'd0);
        check({p, "_out_result"}, 32'(bus.out_result), 32'd0);
        check({p, "_out_carry"},  32'(bus.out_carry),  32'd0);
        check({p, "_out_zero"},   32'(bus.out_zero),   32'd0);
        check({p, "_out_sel"},    32'(bus.out_sel),    32'd0);
        check({p, "_alu_a"},      32'(bus.alu_a),      32'd0);
        check({p, "_alu_b"},      32'(bus.alu_b),      32'd0);
        check({p, "_alu_sel"},    32'(bus.alu_sel),    32'd0);
    endtask

    // ---------------- scoreboard: one compare per output transfer ----------------
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(exp_q.size()), 32'd1);
            end else begin
                check("out_data", 32'(out_word()), 32'(exp_q.pop_front()));
            end
            xfers++;
            xfer_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b,
                            input logic [1:0] sel, input logic [7:0] exp);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sel   = sel;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        bus.in_valid = 1'b0;
        check("push_accept", 32'(acc), 32'd1);
        if (acc) exp_q.push_back(exp);
    endtask

    task automatic wait_drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !bus.out_valid;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // ---------------- directed vectors: {a, b, sel} and expected words ----------------
    logic [9:0] full_cmd [6] = '{
        {4'h1, 4'h2, 2'b00}, {4'h3, 4'h4, 2'b01}, {4'hF, 4'hF, 2'b00},
        {4'h6, 4'h3, 2'b10}, {4'h8, 4'h1, 2'b11}, {4'h7, 4'h7, 2'b00}};
    logic [7:0] full_exp [6] = '{8'h03, 8'h4F, 8'h2E, 8'h82, 8'hC9, 8'h0E};

    logic [9:0] wrap_cmd [8] = '{
        {4'h2, 4'h2, 2'b00}, {4'h8, 4'h8, 2'b00}, {4'h7, 4'h2, 2'b01},
        {4'h0, 4'h1, 2'b01}, {4'h5, 4'hA, 2'b10}, {4'hF, 4'h3, 2'b10},
        {4'h0, 4'h0, 2'b11}, {4'h4, 4'h2, 2'b11}};
    logic [7:0] wrap_exp [8] = '{8'h04, 8'h30, 8'h65, 8'h4F, 8'h90, 8'h83, 8'hD0, 8'hC6};

    logic [9:0] pp_cmd [6] = '{
        {4'h1, 4'h1, 2'b00}, {4'h2, 4'h1, 2'b01}, {4'h9, 4'h3, 2'b10},
        {4'h6, 4'h6, 2'b11}, {4'h9, 4'h6, 2'b00}, {4'h4, 4'h4, 2'b01}};
    logic [7:0] pp_exp [6] = '{8'h02, 8'h61, 8'h81, 8'hC6, 8'h0F, 8'h70};

    logic [9:0] rst_cmd [4] = '{
        {4'h3, 4'h3, 2'b00}, {4'h8, 4'h1, 2'b01}, {4'hA, 4'h6, 2'b10}, {4'h1, 4'h4, 2'b11}};
    logic [7:0] rst_exp [4] = '{8'h06, 8'h67, 8'h82, 8'hC5};

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int acc_cnt;
        logic acc;

        bus.in_valid  = 1'b0;
        bus.in_a      = 4'd0;
        bus.in_b      = 4'd0;
        bus.in_sel    = 2'd0;
        bus.out_ready = 1'b0;

        // Reset
        #2 rst_n = 1'b0;
        #1 check_reset("rst_init");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Add with carry, one-cycle latency
        bus.out_ready = 1'b1;
        push_cmd(4'h9, 4'h8, 2'b00, 8'h21);
        check("add_not_yet_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_word", 32'(out_word()), 32'h21);
        wait_drain("add_drain");

        // Sub and logic flags, back-to-back
        @(posedge clk);
        #1;
        base = xfer_cyc.size();
        push_cmd(4'h5, 4'h5, 2'b01, 8'h70);
        push_cmd(4'hC, 4'h3, 2'b10, 8'h90);
        push_cmd(4'hA, 4'h5, 2'b11, 8'hCF);
        wait_drain("sub_drain");
        check("sub_count", 32'(xfer_cyc.size() - base), 32'd3);
        if (xfer_cyc.size() >= base + 3) begin
            check("sub_consecutive", 32'(xfer_cyc[base + 2] - xfer_cyc[base]), 32'd2);
        end

        // Backpressure / full: 6 offered, 5 accepted
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            {bus.in_a, bus.in_b, bus.in_sel} = full_cmd[k];
            acc = 1'b0;
            for (int t = 0; t < 3; t++) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                #1;
                if (acc) break;
            end
            if (acc) begin
                acc_cnt++;
                exp_q.push_back(full_exp[k]);
            end
        end
        bus.in_valid = 1'b0;
        check("full_accept_cnt", 32'(acc_cnt), 32'd5);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("full_in_ready", 32'(bus.in_ready), 32'd0);
            check("full_level", 32'(bus.level), 32'd4);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_hold", 32'(out_word()), 32'h03);
        end

        // Drain and wrap: 5 held + 8 more at full rate
        @(posedge clk);
        #1;
        base = xfers;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push_cmd(wrap_cmd[k][9:6], wrap_cmd[k][5:2], wrap_cmd[k][1:0], wrap_exp[k]);
        end
        wait_drain("wrap_drain");
        check("wrap_count", 32'(xfers - base), 32'd13);
        @(negedge clk);
        check("wrap_level", 32'(bus.level), 32'd0);
        check("wrap_out_valid", 32'(bus.out_valid), 32'd0);
        check("wrap_in_ready", 32'(bus.in_ready), 32'd1);
        check("wrap_alu", {22'd0, bus.alu_a, bus.alu_b, bus.alu_sel}, 32'd0);

        // Simultaneous push and pop at level 2
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_cmd(pp_cmd[k][9:6], pp_cmd[k][5:2], pp_cmd[k][1:0], pp_exp[k]);
        end
        @(negedge clk);
        check("pp_level_pre", 32'(bus.level), 32'd2);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int k = 3; k < 6; k++) begin
            bus.in_valid = 1'b1;
            {bus.in_a, bus.in_b, bus.in_sel} = pp_cmd[k];
            @(negedge clk);
            check("pp_level", 32'(bus.level), 32'd2);
            acc = bus.in_ready;
            check("pp_in_ready", 32'(acc), 32'd1);
            @(posedge clk);
            #1;
            if (acc) exp_q.push_back(pp_exp[k]);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pp_level_post", 32'(bus.level), 32'd2);
        wait_drain("pp_drain");

        // Reset mid-stream with level=3 and a held result
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_cmd(rst_cmd[k][9:6], rst_cmd[k][5:2], rst_cmd[k][1:0], rst_exp[k]);
        end
        @(negedge clk);
        check("pre_rst_level", 32'(bus.level), 32'd3);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        exp_q.delete();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("no_stale_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        push_cmd(4'h1, 4'h1, 2'b00, 8'h02);
        @(posedge clk);
        #1;
        check("post_rst_word", 32'(out_word()), 32'h02);
        wait_drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
